// File: rtl/coin_pkg.sv
// ---------------------------------------------------------------------------
// coin_pkg
// Shared types and constants for the coin acceptor front end.
//   coin_code_t : 2-bit code driven onto the vending machine coins input
//   acc_state_t : acceptor FSM state encoding
//   COIN_VALUE_*: coin values in cents
// ---------------------------------------------------------------------------
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_code_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEASURE  = 3'd1,
    ST_CLASSIFY = 3'd2,
    ST_EMIT     = 3'd3,
    ST_JAM      = 3'd4
  } acc_state_t;

  localparam int COIN_VALUE_5  = 5;
  localparam int COIN_VALUE_10 = 10;
  localparam int COIN_VALUE_25 = 25;

endpackage

// File: rtl/sense_debounce.sv
// ---------------------------------------------------------------------------
// sense_debounce
// Synchronises the raw optical coin sensor and debounces it.
//   clk        : system clock
//   rst        : asynchronous, active-low reset
//   coin_sense : raw asynchronous sensor level (1 = coin in beam)
//   deb        : debounced level
//   deb_rise   : one-cycle pulse, coincident with deb going 0->1
//   deb_fall   : one-cycle pulse, coincident with deb going 1->0
// The debounced level follows the synchronised level only after the new
// value has been seen for DEB_CYCLES consecutive cycles.
// ---------------------------------------------------------------------------
module sense_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_sense,
  output logic deb,
  output logic deb_rise,
  output logic deb_fall
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [DW-1:0]          deb_cnt_reg;
  logic                   deb_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   sync_lvl;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = coin_sense;
      end else begin : g_rest
        assign stage_in = sync_reg[gi-1];
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_reg[gi] <= 1'b0;
        else      sync_reg[gi] <= stage_in;
      end
    end
  endgenerate

  assign sync_lvl = sync_reg[SYNC_STAGES-1];

  // The counter tracks how long the synchronised level has disagreed with
  // deb; any agreement restarts it, so short glitches never reach deb.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt_reg <= '0;
      deb_reg     <= 1'b0;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (sync_lvl != deb_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          deb_cnt_reg <= '0;
          deb_reg     <= sync_lvl;
          rise_reg    <= sync_lvl;
          fall_reg    <= !sync_lvl;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  assign deb      = deb_reg;
  assign deb_rise = rise_reg;
  assign deb_fall = fall_reg;

endmodule

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
// Coin validator in front of the vending machine: debounces the optical
// sensor, measures the coin pulse width and classifies it.
//   clk        : system clock
//   rst        : asynchronous, active-low reset
//   coin_sense : raw sensor level (1 = coin in beam)
//   enable     : 1 = vending machine accepts coins (sampled in CLASSIFY)
//   coins      : one-cycle strobe, 00 none / 01 5c / 10 10c / 11 25c
//   reject     : one-cycle pulse, coin routed to return chute
//   jam        : level, sensor blocked for JAM_CYCLES or more
//   busy       : 1 whenever the FSM is not idle
// Optional (macro COIN_ACCEPTOR_STATS_EN):
//   stats_clr  : synchronous clear of the statistics counters
//   cnt5, cnt10, cnt25, cnt_rej : saturating strobe counters
// Raw falling edge to strobe is SYNC_STAGES + DEB_CYCLES + 2 cycles.
// ---------------------------------------------------------------------------
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int W5_MIN      = 8,
  parameter int W5_MAX      = 15,
  parameter int W10_MIN     = 16,
  parameter int W10_MAX     = 31,
  parameter int W25_MIN     = 32,
  parameter int W25_MAX     = 63,
  parameter int JAM_CYCLES  = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_sense,
  input  logic             enable,
  output logic [1:0]       coins,
  output logic             reject,
  output logic             jam,
  output logic             busy
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt5,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt25,
  output logic [CNT_W-1:0] cnt_rej
`endif
);

  localparam logic [CNT_W-1:0] W5_LO  = CNT_W'(W5_MIN);
  localparam logic [CNT_W-1:0] W5_HI  = CNT_W'(W5_MAX);
  localparam logic [CNT_W-1:0] W10_LO = CNT_W'(W10_MIN);
  localparam logic [CNT_W-1:0] W10_HI = CNT_W'(W10_MAX);
  localparam logic [CNT_W-1:0] W25_LO = CNT_W'(W25_MIN);
  localparam logic [CNT_W-1:0] W25_HI = CNT_W'(W25_MAX);
  localparam logic [CNT_W-1:0] JAM_W  = CNT_W'(JAM_CYCLES);

  logic deb;
  logic deb_rise;
  logic deb_fall;

  acc_state_t       state_reg,  state_next;
  logic [CNT_W-1:0] width_reg,  width_next;
  coin_code_t       coins_reg,  coins_next;
  logic             reject_reg, reject_next;
  coin_code_t       win_code;

  sense_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_sense (
    .clk        (clk),
    .rst        (rst),
    .coin_sense (coin_sense),
    .deb        (deb),
    .deb_rise   (deb_rise),
    .deb_fall   (deb_fall)
  );

  // Window lookup on the measured width; all bounds inclusive.
  always_comb begin
    win_code = COIN_NONE;
    if (width_reg >= W5_LO && width_reg <= W5_HI)
      win_code = COIN_5;
    else if (width_reg >= W10_LO && width_reg <= W10_HI)
      win_code = COIN_10;
    else if (width_reg >= W25_LO && width_reg <= W25_HI)
      win_code = COIN_25;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      width_reg  <= '0;
      coins_reg  <= COIN_NONE;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      width_reg  <= width_next;
      coins_reg  <= coins_next;
      reject_reg <= reject_next;
    end
  end

  // Strobes are computed one state ahead so they leave the block registered
  // during the EMIT cycle (or on the JAM->IDLE release).
  always_comb begin
    state_next  = state_reg;
    width_next  = width_reg;
    coins_next  = COIN_NONE;
    reject_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (deb_rise) begin
          state_next = ST_MEASURE;
          width_next = CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (deb_fall) begin
          state_next = ST_CLASSIFY;
        end else if (width_reg == JAM_W) begin
          state_next = ST_JAM;
        end else if (deb) begin
          width_next = width_reg + 1'b1;
        end
      end
      ST_CLASSIFY: begin
        state_next = ST_EMIT;
        if (enable && win_code != COIN_NONE) coins_next  = win_code;
        else                                 reject_next = 1'b1;
      end
      ST_EMIT: begin
        state_next = ST_IDLE;
      end
      ST_JAM: begin
        if (deb_fall) begin
          state_next  = ST_IDLE;
          reject_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign coins  = coins_reg;
  assign reject = reject_reg;
  assign jam    = (state_reg == ST_JAM);
  assign busy   = (state_reg != ST_IDLE);

`ifdef COIN_ACCEPTOR_STATS_EN
  // Counter order: 5c, 10c, 25c, reject.
  logic [3:0]       stat_inc;
  logic [CNT_W-1:0] stat_cnt [4];

  assign stat_inc = {reject_reg, coins_reg == COIN_25,
                     coins_reg == COIN_10, coins_reg == COIN_5};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          stat_cnt[gi] <= '0;
        else if (stats_clr)
          stat_cnt[gi] <= '0;
        else if (stat_inc[gi] && stat_cnt[gi] != '1)
          stat_cnt[gi] <= stat_cnt[gi] + 1'b1;
      end
    end
  endgenerate

  assign cnt5    = stat_cnt[0];
  assign cnt10   = stat_cnt[1];
  assign cnt25   = stat_cnt[2];
  assign cnt_rej = stat_cnt[3];
`endif

endmodule
